// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch control sequencer.
package stopwatch_pkg;

  localparam int DIGITS_W = 16;

  // Control sequencer states. IDLE is the reset state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUNNING = 3'd1,
    LAP     = 3'd2,
    STOPPED = 3'd3,
    CLEAR   = 3'd4
  } sw_state_t;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter that
// qualifies level changes, and a one-cycle press pulse on a debounced 0->1.
module button_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter tracks how long the synchronized input has disagreed with the
  // debounced level; the level only flips after DB_CYCLES of disagreement.
  // The press pulse is registered on the same edge the level rises.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced start/stop and lap/clear buttons
// drive a Moore FSM producing the counter run/clear controls, plus a lap
// snapshot register and the live/frozen display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_start,
  input  logic                btn_lap,
  input  logic [DIGITS_W-1:0] live_digits,
  output logic                run,
  output logic                clr,
  output logic [DIGITS_W-1:0] disp_digits,
  output logic                lap_active
);

  // Index 0 is start/stop, index 1 is lap/clear.
  logic [1:0] btn_raw_vec;
  logic [1:0] btn_level_vec;
  logic [1:0] btn_press_vec;
  logic       start_press, lap_press;

  assign btn_raw_vec = {btn_lap, btn_start};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    button_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_raw_vec[gi]),
      .level   (btn_level_vec[gi]),
      .press   (btn_press_vec[gi])
    );
  end

  assign start_press = btn_press_vec[0];
  assign lap_press   = btn_press_vec[1];

  sw_state_t           state_q, state_d;
  logic [DIGITS_W-1:0] lap_reg_q, lap_reg_d;

  // Next-state logic. Start is tested first so a coincident lap press is
  // discarded; CLEAR lasts one cycle and ignores both buttons.
  always_comb begin
    state_d   = state_q;
    lap_reg_d = lap_reg_q;
    unique case (state_q)
      IDLE: begin
        if (start_press)    state_d = RUNNING;
        else if (lap_press) state_d = CLEAR;
      end
      RUNNING: begin
        if (start_press) begin
          state_d = STOPPED;
        end else if (lap_press) begin
          state_d   = LAP;
          lap_reg_d = live_digits;
        end
      end
      LAP: begin
        if (start_press)    state_d = STOPPED;
        else if (lap_press) state_d = RUNNING;
      end
      STOPPED: begin
        if (start_press)    state_d = RUNNING;
        else if (lap_press) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and lap snapshot registers; only reset clears the snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lap_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      lap_reg_q <= lap_reg_d;
    end
  end

  // Moore outputs decoded from the state register only; the display mux is
  // the one combinational path and it sees only live_digits.
  always_comb begin
    run         = (state_q == RUNNING) || (state_q == LAP);
    clr         = (state_q == CLEAR);
    lap_active  = (state_q == LAP);
    disp_digits = lap_active ? lap_reg_q : live_digits;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with a small debounce window.
module tb_stopwatch_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_lap = 1'b0;
  logic [15:0] live_digits = 16'h1234;
  logic        run, clr, lap_active;
  logic [15:0] disp_digits;

  stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_start   (btn_start),
    .btn_lap     (btn_lap),
    .live_digits (live_digits),
    .run         (run),
    .clr         (clr),
    .disp_digits (disp_digits),
    .lap_active  (lap_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        run;
    logic        clr;
    logic        lap;
    logic [15:0] disp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input string tag, input logic r, input logic c,
                            input logic l, input logic [15:0] d);
    exp_t e;
    e.tag = tag; e.run = r; e.clr = c; e.lap = l; e.disp = d;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [18:0] obs, exp;
    e   = sb.pop_front();
    obs = {run, clr, lap_active, disp_digits};
    exp = {e.run, e.clr, e.lap, e.disp};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed run=%b clr=%b lap=%b disp=%h, expected run=%b clr=%b lap=%b disp=%h",
             e.tag, run, clr, lap_active, disp_digits, e.run, e.clr, e.lap, e.disp);
    end
    $display("txn %-14s run=%b clr=%b lap=%b disp=%h", e.tag, run, clr, lap_active, disp_digits);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
    $display("txn %-14s value=%0d", tag, obs);
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return run;
      1:       return lap_active;
      default: return clr;
    endcase
  endfunction

  // Bounded wait for an output to reach a level; timeout is a failure.
  task automatic wait_level(input string tag, input int sel, input logic val, input int budget);
    int n = 0;
    while (cur(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (cur(sel) === val) else begin
      errors++;
      $error("FAIL %s: observed %b after %0d cycles, expected %b", tag, cur(sel), n, val);
    end
    $display("txn %-14s reached %b after %0d cycles", tag, val, n);
  endtask

  // Clean press of one or both buttons, then time for release to debounce.
  task automatic press(input bit s, input bit l, input int hold);
    if (s) btn_start = 1'b1;
    if (l) btn_lap = 1'b1;
    repeat (hold) @(negedge clk);
    btn_start = 1'b0;
    btn_lap = 1'b0;
    repeat (DB + 6) @(negedge clk);
  endtask

  initial begin
    int nclr;
    int run_at_clr;

    // 1. Reset and idle behaviour.
    @(negedge clk);
    expect_out("in_reset", 0, 0, 0, 16'h1234); check_out();
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    expect_out("idle", 0, 0, 0, 16'h1234); check_out();

    // 2. Start press: run rises within 2+DB+1 cycles, held press is one event.
    btn_start = 1'b1;
    wait_level("start_latency", 0, 1'b1, 2 + DB + 2);
    repeat (4) @(negedge clk);
    btn_start = 1'b0;
    repeat (DB + 6) @(negedge clk);
    expect_out("running", 1, 0, 0, 16'h1234); check_out();
    press(1, 0, 10);
    expect_out("stopped", 0, 0, 0, 16'h1234); check_out();

    // 3. Bounce shorter than the debounce window does nothing.
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      repeat (2) @(negedge clk);
    end
    btn_start = 1'b0;
    repeat (DB + 6) @(negedge clk);
    expect_out("bounce", 0, 0, 0, 16'h1234); check_out();

    // 4. Lap freeze and unfreeze.
    press(1, 0, 10);
    live_digits = 16'h0512;
    #1;
    expect_out("run_again", 1, 0, 0, 16'h0512); check_out();
    btn_lap = 1'b1;
    wait_level("lap_latency", 1, 1'b1, 2 + DB + 2);
    live_digits = 16'h0600;
    repeat (3) @(negedge clk);
    btn_lap = 1'b0;
    repeat (DB + 6) @(negedge clk);
    expect_out("lap_frozen", 1, 0, 1, 16'h0512); check_out();
    press(0, 1, 10);
    expect_out("lap_unfreeze", 1, 0, 0, 16'h0600); check_out();
    live_digits = 16'h0601;
    #1;
    expect_out("live_follow", 1, 0, 0, 16'h0601); check_out();

    // 5. Clear from STOPPED and from IDLE: one clr per held press.
    press(1, 0, 10);
    expect_out("stop_for_clr", 0, 0, 0, 16'h0601); check_out();
    for (int pass = 0; pass < 2; pass++) begin
      nclr = 0;
      run_at_clr = 0;
      btn_lap = 1'b1;
      for (int i = 0; i < 20 + DB + 6; i++) begin
        @(negedge clk);
        if (i == 19) btn_lap = 1'b0;
        if (clr === 1'b1) begin
          nclr++;
          if (run === 1'b1) run_at_clr++;
        end
      end
      check_int(pass == 0 ? "clr_cnt_stop" : "clr_cnt_idle", nclr, 1);
      check_int("clr_run_low", run_at_clr, 0);
      expect_out("idle_after_clr", 0, 0, 0, 16'h0601); check_out();
    end

    // 6. Coincident presses in RUNNING: start wins, no snapshot taken.
    press(1, 0, 10);
    live_digits = 16'h0999;
    press(1, 1, 10);
    expect_out("prio_stopped", 0, 0, 0, 16'h0999); check_out();
    check_int("prio_lap_reg", int'(dut.lap_reg_q), 16'h0512);

    // Enter LAP with a fresh snapshot, then reset asynchronously mid-cycle.
    press(1, 0, 10);
    live_digits = 16'h0777;
    press(0, 1, 10);
    live_digits = 16'h0778;
    #1;
    expect_out("lap_again", 1, 0, 1, 16'h0777); check_out();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 16'h0778); check_out();
    check_int("reset_lap_reg", int'(dut.lap_reg_q), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    expect_out("post_reset", 0, 0, 0, 16'h0778); check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
